sub_fp_single_seq: RTL and testbench

//  Sequential single-precision (IEEE-754 binary32) subtractor: out = a - b.

---
 rtl/fp_single_pkg.sv | 26 ++
 rtl/fp_align_shift_single.sv | 25 ++
 rtl/sub_fp_single_seq.sv | 178 +++++++++++++++++
 tb/tb_sub_fp_single_seq.sv | 108 ++++++++++
 4 files changed

// File: rtl/fp_single_pkg.sv
// Shared binary32 constants, FSM state encoding and mantissa helper for the
// single-precision FP blocks.
package fp_single_pkg;

  localparam int          EXP_W   = 8;
  localparam int          MAN_W   = 23;
  localparam int          BIAS    = 127;
  localparam int          MANT_W  = 28;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    ADDSUB = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Working mantissa {carry, hidden, frac, guard, round, sticky}; zero-exponent operands are zero.
  function automatic logic [27:0] ext_mant(input logic [7:0] e, input logic [22:0] f);
    ext_mant = (e == 8'd0) ? 28'd0 : {2'b01, f, 3'b000};
  endfunction

endpackage

// File: rtl/fp_align_shift_single.sv
// Right barrel shift of a 28-bit working mantissa; every bit shifted out is
// ORed into bit 0. Amounts of 27 or more leave only the sticky bit.
module fp_align_shift_single
  import fp_single_pkg::*;
(
  input  logic [MANT_W-1:0] din,
  input  logic [4:0]        amt,
  output logic [MANT_W-1:0] dout
);

  logic [27:0] shifted_s;
  logic [27:0] mask_s;

  // shift with sticky collection of the dropped bits
  always_comb begin
    shifted_s = din >> amt;
    mask_s    = (28'd1 << amt) - 28'd1;
    if (amt >= 5'd27) begin
      dout = {27'd0, |din};
    end else begin
      dout = {shifted_s[27:1], shifted_s[0] | (|(din & mask_s))};
    end
  end

endmodule

// File: rtl/sub_fp_single_seq.sv
// Sequential binary32 subtractor out = a - b, flush-to-zero, round-to-nearest-even,
// one operation in flight, valid/ready on both sides.
module sub_fp_single_seq #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000,
  parameter bit          FTZ  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        out_ovf,
  output logic        out_inexact
);
  import fp_single_pkg::*;

  state_t      state_r, state_nx_s;
  logic [31:0] a_r, b_r, res_r;
  logic        sign_r, eff_sub_r, first_r, byp_r, res_inx_r;
  logic [9:0]  exp_r;
  logic [27:0] ma_r, mb_r, mant_r;

  logic [7:0]  ea_s, eb_s, big_e_s, sm_e_s, diff_s;
  logic [22:0] fa_s, fb_s, big_f_s, sm_f_s;
  logic        sbn_s, big_sign_s, special_s;
  logic [31:0] special_val_s;
  logic [4:0]  amt_s;
  logic [27:0] sm_shift_s;
  logic [9:0]  exp_dec_s, exp_rnd_s;
  logic        round_up_s, ovf_s;
  logic [24:0] sum_rnd_s;
  logic [22:0] frac_rnd_s;

  fp_align_shift_single u_align (
    .din  (ext_mant(sm_e_s, sm_f_s)),
    .amt  (amt_s),
    .dout (sm_shift_s)
  );

  // operand ordering, alignment amount and special-value detection
  always_comb begin
    ea_s  = a_r[30:23];
    eb_s  = b_r[30:23];
    fa_s  = (FTZ && (ea_s == 8'd0)) ? 23'd0 : a_r[22:0];
    fb_s  = (FTZ && (eb_s == 8'd0)) ? 23'd0 : b_r[22:0];
    sbn_s = ~b_r[31];
    if ({ea_s, fa_s} >= {eb_s, fb_s}) begin
      big_sign_s = a_r[31];
      big_e_s = ea_s; big_f_s = fa_s; sm_e_s = eb_s; sm_f_s = fb_s;
    end else begin
      big_sign_s = sbn_s;
      big_e_s = eb_s; big_f_s = fb_s; sm_e_s = ea_s; sm_f_s = fa_s;
    end
    diff_s    = big_e_s - sm_e_s;
    amt_s     = (diff_s >= 8'd27) ? 5'd27 : diff_s[4:0];
    special_s = (ea_s == EXP_MAX) || (eb_s == EXP_MAX);
    if (((ea_s == EXP_MAX) && (a_r[22:0] != 23'd0)) || ((eb_s == EXP_MAX) && (b_r[22:0] != 23'd0))) begin
      special_val_s = QNAN;
    end else if ((ea_s == EXP_MAX) && (eb_s == EXP_MAX)) begin
      special_val_s = (a_r[31] != sbn_s) ? QNAN : {a_r[31], EXP_MAX, 23'd0};
    end else if (ea_s == EXP_MAX) begin
      special_val_s = {a_r[31], EXP_MAX, 23'd0};
    end else begin
      special_val_s = {sbn_s, EXP_MAX, 23'd0};
    end
  end

  // normalise step and round-to-nearest-even on guard/round/sticky
  always_comb begin
    exp_dec_s  = exp_r - 10'd1;
    round_up_s = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
    sum_rnd_s  = {1'b0, mant_r[26:3]} + {24'd0, round_up_s};
    exp_rnd_s  = exp_r + {9'd0, sum_rnd_s[24]};
    frac_rnd_s = sum_rnd_s[24] ? sum_rnd_s[23:1] : sum_rnd_s[22:0];
    ovf_s      = (exp_rnd_s >= 10'd255);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:   state_nx_s = in_valid ? ALIGN : IDLE;
      ALIGN:  state_nx_s = special_s ? ROUND : ADDSUB;
      ADDSUB: state_nx_s = NORM;
      NORM: begin
        if (first_r) begin
          state_nx_s = (mant_r[27] || (mant_r == 28'd0) || mant_r[26]) ? ROUND : NORM;
        end else begin
          state_nx_s = ((exp_dec_s == 10'd0) || mant_r[25]) ? ROUND : NORM;
        end
      end
      ROUND:  state_nx_s = DONE;
      DONE:   state_nx_s = out_ready ? IDLE : DONE;
      default: state_nx_s = IDLE;
    endcase
  end

  // datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= 32'd0; b_r <= 32'd0; res_r <= 32'd0;
      sign_r <= 1'b0; eff_sub_r <= 1'b0; first_r <= 1'b0; byp_r <= 1'b0; res_inx_r <= 1'b0;
      exp_r <= 10'd0; ma_r <= 28'd0; mb_r <= 28'd0; mant_r <= 28'd0;
      in_ready <= 1'b1; out_valid <= 1'b0; out <= 32'd0; out_ovf <= 1'b0; out_inexact <= 1'b0;
    end else begin
      in_ready  <= (state_nx_s == IDLE);
      out_valid <= (state_nx_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
          end
        end
        ALIGN: begin
          sign_r    <= big_sign_s;
          eff_sub_r <= a_r[31] ^ sbn_s;
          exp_r     <= {2'b00, big_e_s};
          ma_r      <= ext_mant(big_e_s, big_f_s);
          mb_r      <= sm_shift_s;
          byp_r     <= special_s;
          res_r     <= special_val_s;
          res_inx_r <= 1'b0;
          first_r   <= 1'b1;
        end
        ADDSUB: mant_r <= eff_sub_r ? (ma_r - mb_r) : (ma_r + mb_r);
        NORM: begin
          first_r <= 1'b0;
          if (first_r) begin
            if (mant_r[27]) begin
              mant_r <= {1'b0, mant_r[27:2], mant_r[1] | mant_r[0]};
              exp_r  <= exp_r + 10'd1;
            end else if (mant_r == 28'd0) begin
              // only an add of two zeros keeps the operand sign; cancellation gives +0
              byp_r     <= 1'b1;
              res_r     <= {sign_r & ~eff_sub_r, 31'd0};
              res_inx_r <= 1'b0;
            end else begin
              mant_r <= mant_r;
            end
          end else if (exp_dec_s == 10'd0) begin
            byp_r     <= 1'b1;
            res_r     <= {sign_r, 31'd0};
            res_inx_r <= 1'b1;
          end else begin
            mant_r <= mant_r << 1;
            exp_r  <= exp_dec_s;
          end
        end
        ROUND: begin
          if (byp_r) begin
            out <= res_r; out_ovf <= 1'b0; out_inexact <= res_inx_r;
          end else if (ovf_s) begin
            out <= {sign_r, EXP_MAX, 23'd0}; out_ovf <= 1'b1; out_inexact <= |mant_r[2:0];
          end else begin
            out <= {sign_r, exp_rnd_s[7:0], frac_rnd_s}; out_ovf <= 1'b0; out_inexact <= |mant_r[2:0];
          end
        end
        DONE: out <= out;
        default: out <= out;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_fp_single_seq.sv
// Directed-vector bench for sub_fp_single_seq: results, flags, latency,
// back-pressure hold and reset abort.
module tb_sub_fp_single_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_ovf, out_inexact;
  logic [31:0] a, b, out;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  sub_fp_single_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_ovf(out_ovf),
    .out_inexact(out_inexact)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // drive one operand pair; returns at edge 0 + 1 time unit
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eo, input logic eovf, input logic einx,
                        input int elat, input int hold);
    int lat;
    start_op(av, bv);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_out"}, out, eo);
    chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, eovf});
    chk({tag, "_inx"}, {31'd0, out_inexact}, {31'd0, einx});
    chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_out"}, out, eo);
      chk({tag, "_hold_vld"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int vld_seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_flags", {30'd0, out_ovf, out_inexact}, 32'd0);
    @(negedge clk) rst = 1'b0;

    run_op("three_minus_one", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 4, 0);
    run_op("cancel_l24",      32'h3F80_0000, 32'h3F7F_FFFF, 32'h3380_0000, 1'b0, 1'b0, 28, 0);
    run_op("tie_round_up",    32'h4B80_0000, 32'h3F00_0000, 32'h4B80_0000, 1'b0, 1'b1, 5, 0);
    run_op("tie_round_even",  32'h3F80_0000, 32'hB380_0000, 32'h3F80_0000, 1'b0, 1'b1, 4, 0);
    run_op("swap_negative",   32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 1'b0, 1'b0, 4, 0);
    run_op("x_minus_x",       32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0, 4, 0);
    run_op("nz_minus_pz",     32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 4, 0);
    run_op("pz_minus_nz",     32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 4, 0);
    run_op("nz_minus_nz",     32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 4, 0);
    run_op("inf_minus_inf",   32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, 2, 0);
    run_op("inf_minus_one",   32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0, 1'b0, 2, 0);
    run_op("nan_in",          32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, 2, 0);
    run_op("overflow_hold",   32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 1'b1, 1'b0, 4, 3);

    // abort during the long normalisation of the 2^-24 case
    start_op(32'h3F80_0000, 32'h3F7F_FFFF);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    vld_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) vld_seen++;
    end
    chk("abort_no_result", 32'(vld_seen), 32'd0);
    run_op("after_abort", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
